// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and FSM state encoding for the fetch sequencer.
// Contents : START_PC_DEFAULT - reset fetch address
//            PC_INC           - byte distance between sequential fetches
//            fetch_state_t    - 2-bit FSM state type (IDLE/REQ/WAIT/HOLD)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] START_PC_DEFAULT = 32'hBFC0_0000;
    localparam int unsigned PC_INC           = 4;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;  // one-cycle settle after reset
    localparam fetch_state_t ST_REQ  = 2'd1;  // presenting fetch_pc to memory
    localparam fetch_state_t ST_WAIT = 2'd2;  // one request outstanding
    localparam fetch_state_t ST_HOLD = 2'd3;  // buffer full, waiting on decode

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_obuf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_obuf
// Purpose  : One-entry registered buffer between fetch and decode.
// Ports    : clk, rst_n          - clock, async active-low reset
//            load                - capture load_pc/load_inst/load_adel, set valid
//            clear               - drop the entry (wins over load)
//            load_pc/inst/adel   - entry contents to capture
//            valid/pc/inst/adel  - registered entry presented to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_obuf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [ADDR_W-1:0] load_inst,
    input  logic              load_adel,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] inst,
    output logic              adel
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            adel  <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            adel  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
            adel  <= load_adel;
        end
    end

endmodule : fetch_obuf
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Purpose  : Instruction-fetch sequencer. Owns the fetch PC, selects between
//            sequential / branch / exception targets, runs a single-outstanding
//            req/addr_ok/data_ok memory handshake and feeds decode through a
//            one-entry valid/ready buffer.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            exc_valid/exc_target       - exception redirect (priority)
//            br_valid/br_target         - branch redirect
//            inst_req/inst_addr         - memory request channel
//            inst_addr_ok/data_ok/rdata - memory responses
//            if_valid/pc/inst/adel      - buffered entry to decode
//            id_ready                   - decode accepts the entry
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] START_PC = START_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [ADDR_W-1:0] inst_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_inst,
    output logic              if_adel,
    input  logic              id_ready
);

    // Increment is applied to the word index so bits [1:0] ride through
    // untouched and a misaligned PC stays misaligned.
    localparam logic [ADDR_W-3:0] c_word_inc = (ADDR_W-2)'(PC_INC / 4);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_drop;

    logic              w_redir;
    logic [ADDR_W-1:0] w_target;
    logic              w_aligned;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_load;
    logic              w_clear;
    logic [ADDR_W-1:0] w_load_pc;
    logic [ADDR_W-1:0] w_load_inst;
    logic              w_load_adel;

    assign w_redir   = exc_valid | br_valid;
    assign w_target  = exc_valid ? exc_target : br_target;
    assign w_aligned = (r_fetch_pc[1:0] == 2'b00);
    assign w_pc_inc  = {r_fetch_pc[ADDR_W-1:2] + c_word_inc, r_fetch_pc[1:0]};

    assign inst_addr = r_fetch_pc;
    assign inst_req  = (r_state == ST_REQ) && w_aligned;

    // Buffer control: misaligned PCs are reported as an address-error entry
    // instead of being sent to memory.
    always_comb begin
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_load_pc   = r_fetch_pc;
        w_load_inst = '0;
        w_load_adel = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (!w_redir && !w_aligned) begin
                    w_load      = 1'b1;
                    w_load_adel = 1'b1;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok && !r_drop && !w_redir) begin
                    w_load      = 1'b1;
                    w_load_pc   = r_inflight_pc;
                    w_load_inst = inst_rdata;
                end
            end
            ST_HOLD: begin
                // A redirect kills the entry even if decode is ready.
                if (w_redir || id_ready) begin
                    w_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= START_PC;
            r_inflight_pc <= '0;
            r_drop        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_target;
                        // Old address already accepted: its response must
                        // be swallowed.
                        if (inst_req && inst_addr_ok) begin
                            r_inflight_pc <= r_fetch_pc;
                            r_drop        <= 1'b1;
                            r_state       <= ST_WAIT;
                        end
                    end else if (!w_aligned) begin
                        r_state <= ST_HOLD;
                    end else if (inst_addr_ok) begin
                        r_inflight_pc <= r_fetch_pc;
                        r_fetch_pc    <= w_pc_inc;
                        r_drop        <= 1'b0;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        r_state <= (!r_drop && !w_redir) ? ST_HOLD : ST_REQ;
                        if (w_redir) begin
                            r_fetch_pc <= w_target;
                        end
                    end else if (w_redir) begin
                        r_drop     <= 1'b1;
                        r_fetch_pc <= w_target;
                    end
                end
                ST_HOLD: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_target;
                        r_state    <= ST_REQ;
                    end else if (id_ready) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    fetch_obuf #(
        .ADDR_W (ADDR_W)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .clear     (w_clear),
        .load_pc   (w_load_pc),
        .load_inst (w_load_inst),
        .load_adel (w_load_adel),
        .valid     (if_valid),
        .pc        (if_pc),
        .inst      (if_inst),
        .adel      (if_adel)
    );

endmodule : fetch_pc_ctrl
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_ctrl
// Purpose  : Self-checking bench for fetch_pc_ctrl. Inputs change 1ns after
//            the rising edge; outputs are checked there. A negedge monitor
//            pops delivered entries against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_target = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;
    logic        id_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        aok;
        logic        dok;
        logic [31:0] sb_pc;     // address whose data is returned on dok
        logic        rdy;
        logic        push;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[14];

    fetch_pc_ctrl #(
        .ADDR_W   (32),
        .START_PC (32'hBFC0_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exc_valid    (exc_valid),
        .exc_target   (exc_target),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel),
        .id_ready     (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0F0F_0F0F;
    endfunction

    function automatic vec_t mk(input logic aok, input logic dok,
                                input logic [31:0] sb_pc, input logic rdy,
                                input logic push, input logic exp_req,
                                input logic [31:0] exp_addr,
                                input logic exp_valid,
                                input logic [31:0] exp_pc);
        vec_t v;
        v.aok = aok; v.dok = dok; v.sb_pc = sb_pc; v.rdy = rdy;
        v.push = push; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_valid = exp_valid; v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then advance past the edge.
    task automatic cyc(input logic aok, input logic dok,
                       input logic [31:0] rdata, input logic rdy,
                       input logic ev, input logic [31:0] et,
                       input logic bv, input logic [31:0] bt);
        inst_addr_ok = aok;
        inst_data_ok = dok;
        inst_rdata   = rdata;
        id_ready     = rdy;
        exc_valid    = ev;
        exc_target   = et;
        br_valid     = bv;
        br_target    = bt;
        tick();
    endtask

    task automatic expect_o(input string tag, input logic req,
                            input logic [31:0] addr, input logic vld);
        chk({tag, "_req"},   {31'd0, inst_req}, {31'd0, req});
        chk({tag, "_addr"},  inst_addr, addr);
        chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, vld});
    endtask

    // Delivery monitor: an entry is consumed when valid && ready with no
    // redirect in the same cycle.
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready && !exc_valid && !br_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got pc %h with empty queue", if_pc);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_pc",   if_pc, e.pc);
                chk("sb_inst", if_inst, e.inst);
                chk("sb_adel", {31'd0, if_adel}, {31'd0, e.adel});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait streaming, then a 5-cycle decode stall (addr_ok during
        // HOLD must be ignored).
        vecs[0]  = mk(0, 0, 32'h0,          1, 0, 1, 32'hBFC0_0000, 0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0,          1, 0, 0, 32'hBFC0_0004, 0, 32'h0);
        vecs[2]  = mk(0, 1, 32'hBFC0_0000,  1, 1, 0, 32'hBFC0_0004, 1, 32'hBFC0_0000);
        vecs[3]  = mk(0, 0, 32'h0,          1, 0, 1, 32'hBFC0_0004, 0, 32'h0);
        vecs[4]  = mk(1, 0, 32'h0,          1, 0, 0, 32'hBFC0_0008, 0, 32'h0);
        vecs[5]  = mk(0, 1, 32'hBFC0_0004,  1, 1, 0, 32'hBFC0_0008, 1, 32'hBFC0_0004);
        vecs[6]  = mk(0, 0, 32'h0,          1, 0, 1, 32'hBFC0_0008, 0, 32'h0);
        vecs[7]  = mk(1, 0, 32'h0,          1, 0, 0, 32'hBFC0_000C, 0, 32'h0);
        vecs[8]  = mk(0, 1, 32'hBFC0_0008,  0, 1, 0, 32'hBFC0_000C, 1, 32'hBFC0_0008);
        vecs[9]  = mk(0, 0, 32'h0,          0, 0, 0, 32'hBFC0_000C, 1, 32'hBFC0_0008);
        vecs[10] = mk(1, 0, 32'h0,          0, 0, 0, 32'hBFC0_000C, 1, 32'hBFC0_0008);
        vecs[11] = mk(0, 0, 32'h0,          0, 0, 0, 32'hBFC0_000C, 1, 32'hBFC0_0008);
        vecs[12] = mk(0, 0, 32'h0,          0, 0, 0, 32'hBFC0_000C, 1, 32'hBFC0_0008);
        vecs[13] = mk(0, 0, 32'h0,          1, 0, 1, 32'hBFC0_000C, 0, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_o("rst", 1'b0, 32'hBFC0_0000, 1'b0);
        chk("rst_pc",   if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_adel", {31'd0, if_adel}, 32'h0);
        rst_n = 1'b1;
        chk("idle_req", {31'd0, inst_req}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].push)
                sbq.push_back({vecs[i].sb_pc, mem_word(vecs[i].sb_pc), 1'b0});
            cyc(vecs[i].aok, vecs[i].dok, mem_word(vecs[i].sb_pc), vecs[i].rdy,
                1'b0, 32'h0, 1'b0, 32'h0);
            expect_o($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                     vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_inst", i), if_inst, mem_word(vecs[i].exp_pc));
                chk($sformatf("v%0d_adel", i), {31'd0, if_adel}, 32'h0);
            end
        end

        // Branch during WAIT: response discarded
        cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        expect_o("bw_acc", 1'b0, 32'hBFC0_0010, 1'b0);
        cyc(0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h8000_1000);
        expect_o("bw_redir", 1'b0, 32'h8000_1000, 1'b0);
        cyc(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        expect_o("bw_wait", 1'b0, 32'h8000_1000, 1'b0);
        cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 32'h0);
        expect_o("bw_drop", 1'b1, 32'h8000_1000, 1'b0);

        // Exception + branch together in HOLD: exception wins, entry killed
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        cyc(0, 1, 32'h1111_2222, 0, 0, 32'h0, 0, 32'h0);
        expect_o("eh_hold", 1'b0, 32'h8000_1004, 1'b1);
        chk("eh_pc",   if_pc, 32'h8000_1000);
        chk("eh_inst", if_inst, 32'h1111_2222);
        cyc(0, 0, 32'h0, 1, 1, 32'hBFC0_0380, 1, 32'h8000_2000);
        expect_o("eh_redir", 1'b1, 32'hBFC0_0380, 1'b0);

        // Redirect in REQ with the old address accepted the same cycle
        cyc(1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h8000_3000);
        expect_o("ra_wait", 1'b0, 32'h8000_3000, 1'b0);
        cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 32'h0);
        expect_o("ra_drop", 1'b1, 32'h8000_3000, 1'b0);

        // Misaligned branch target: address-error entry, no request
        cyc(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0002);
        expect_o("mis_req", 1'b0, 32'h8000_0002, 1'b0);
        sbq.push_back({32'h8000_0002, 32'h0, 1'b1});
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        expect_o("mis_hold", 1'b0, 32'h8000_0002, 1'b1);
        chk("mis_adel", {31'd0, if_adel}, 32'h1);
        chk("mis_pc",   if_pc, 32'h8000_0002);
        chk("mis_inst", if_inst, 32'h0);
        cyc(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        expect_o("mis_acc", 1'b0, 32'h8000_0002, 1'b0);
        cyc(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        expect_o("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0);

        // Wrap of the fetch PC
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        expect_o("wrap_wait", 1'b0, 32'h0000_0000, 1'b0);
        cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

        // Async reset in WAIT, then a stale data_ok
        rst_n = 1'b0;
        #1;
        expect_o("mrst", 1'b0, 32'hBFC0_0000, 1'b0);
        chk("mrst_pc", if_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 32'h0);
        expect_o("stale1", 1'b1, 32'hBFC0_0000, 1'b0);
        cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 32'h0);
        expect_o("stale2", 1'b1, 32'hBFC0_0000, 1'b0);
        cyc(1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        sbq.push_back({32'hBFC0_0000, mem_word(32'hBFC0_0000), 1'b0});
        cyc(0, 1, mem_word(32'hBFC0_0000), 1, 0, 32'h0, 0, 32'h0);
        expect_o("rs_hold", 1'b0, 32'hBFC0_0004, 1'b1);
        cyc(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        expect_o("rs_next", 1'b1, 32'hBFC0_0004, 1'b0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_pc_ctrl
`default_nettype wire
